// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle of the instruction fetch controller.
//   run             : fetch enable
//   imem_address    : address to InstructionMemory (= PC)
//   imem_word       : combinational read data for imem_address
//   redirect        : 1-cycle branch/jump taken pulse
//   redirect_target : new PC, bits [1:0] ignored
//   instr_valid     : prefetch FIFO head valid
//   instr / instr_pc: head instruction and the address it came from
//   instr_ready     : decode accepts the head when instr_valid & instr_ready
//   halted          : controller sits in HALT
//   fetch_count     : words enqueued since reset, wraps at 2^32
// master = fetch controller, slave = memory/decode environment.
interface instr_fetch_ctrl_if;
    logic        run;
    logic [31:0] imem_address;
    logic [31:0] imem_word;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  run, imem_word, redirect, redirect_target, instr_ready,
        output imem_address, instr_valid, instr, instr_pc, halted, fetch_count
    );

    modport slave (
        output run, imem_word, redirect, redirect_target, instr_ready,
        input  imem_address, instr_valid, instr, instr_pc, halted, fetch_count
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller for the MIPS core. Owns the PC, addresses the
// combinational instruction memory, captures the returned word into a small
// prefetch FIFO and hands instructions to decode over valid/ready. Redirects
// flush the FIFO and reload the PC; reading HALT_WORD stops fetching until the
// next redirect.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : instr_fetch_ctrl_if.master (memory, redirect and decode signals)
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t           state, state_nxt;
    logic [31:0]      pc;
    logic [31:0]      fetch_count;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    entry_t           fifo_mem [BUF_DEPTH];

    logic not_empty, full, pop, capture, is_halt_word, push;

    assign not_empty    = (count != '0);
    assign full         = (count == CNT_W'(BUF_DEPTH));
    // A redirect flushes the FIFO, so a handshake in that cycle is discarded.
    assign pop          = not_empty && bus.instr_ready && !bus.redirect;
    // A pop frees a slot in the same cycle, so a full FIFO can still capture.
    assign capture      = (state == FETCH) && bus.run && !bus.redirect && (!full || pop);
    assign is_halt_word = (bus.imem_word == HALT_WORD);
    assign push         = capture && !is_halt_word;

    // NOTE: every signal assigned here gets its default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (bus.redirect) begin
            if (state == HALT) state_nxt = FETCH;
        end else begin
            case (state)
                IDLE:    if (bus.run) state_nxt = FETCH;
                FETCH: begin
                    if (!bus.run)                        state_nxt = IDLE;
                    else if (capture && is_halt_word)    state_nxt = HALT;
                end
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            if (bus.redirect) begin
                pc <= bus.redirect_target & ~32'd3;
            end else if (push) begin
                pc          <= pc + 32'd4;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; an entry is only observed once the
    // occupancy count says it was written, and the outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{word: bus.imem_word, pc: pc};
    end

    assign bus.imem_address = pc;
    assign bus.instr_valid  = not_empty;
    assign bus.instr        = not_empty ? fifo_mem[rd_ptr].word : '0;
    assign bus.instr_pc     = not_empty ? fifo_mem[rd_ptr].pc   : '0;
    assign bus.halted       = (state == HALT);
    assign bus.fetch_count  = fetch_count;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: table-driven vectors, hand-written
// corner sequences (halt, redirect collisions, PC wrap, mid-stall reset) and
// randomized traffic against a queue-based reference model.
module tb_instr_fetch_ctrl;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] W0   = 32'h1000_0000;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    logic rst, rst2;
    always #5 clk = ~clk;

    instr_fetch_ctrl_if bus ();
    instr_fetch_ctrl_if bus2 ();

    instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH), .HALT_WORD(HALT))
        dut (.clk(clk), .rst(rst), .bus(bus));
    instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(DEPTH), .HALT_WORD(HALT))
        dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    // Instruction memory: 64 words at 0x00..0xFC, one word at 0xFFFF_FFFC,
    // everything else unmapped (reads HALT).
    logic [31:0] mem [64];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a[31:8] == 24'd0)     return mem[a[7:2]];
        if (a == 32'hFFFF_FFFC)   return 32'h1234_5678;
        return HALT;
    endfunction

    always_comb bus.imem_word  = mem_read(bus.imem_address);
    always_comb bus2.imem_word = mem_read(bus2.imem_address);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] ins,
                             input logic [31:0] ipc, input logic [31:0] addr,
                             input logic h, input logic [31:0] cnt);
        check({tag, " valid"}, 32'(bus.instr_valid), 32'(v));
        if (v) begin
            check({tag, " instr"}, bus.instr, ins);
            check({tag, " instr_pc"}, bus.instr_pc, ipc);
        end
        check({tag, " addr"}, bus.imem_address, addr);
        check({tag, " halted"}, 32'(bus.halted), 32'(h));
        check({tag, " count"}, bus.fetch_count, cnt);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check({tag, " valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, " instr"}, bus.instr, 32'd0);
        check({tag, " instr_pc"}, bus.instr_pc, 32'd0);
        check({tag, " addr"}, bus.imem_address, 32'd0);
        check({tag, " halted"}, 32'(bus.halted), 32'd0);
        check({tag, " count"}, bus.fetch_count, 32'd0);
        rst = 1'b0;
    endtask

    task automatic apply(input logic run, input logic ready, input logic redir,
                         input logic [31:0] target);
        bus.run             = run;
        bus.instr_ready     = ready;
        bus.redirect        = redir;
        bus.redirect_target = target;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          do_rst;
        bit          run, ready, redir;
        logic [31:0] target;
        bit          v;
        logic [31:0] ins, ipc, addr;
        bit          h;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [31:0] w;
        logic [31:0] p;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_cnt, m_word, r_target;
    bit          m_fetching, m_halted, m_pop, r_run, r_ready, r_redir;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        bus.run = 1'b0; bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
        bus2.run = 1'b0; bus2.instr_ready = 1'b0; bus2.redirect = 1'b0; bus2.redirect_target = '0;
        for (int k = 0; k < 64; k++) mem[k] = W0 + 32'(k);
        @(posedge clk);
        #1;
        rst2 = 1'b0;

        // do_rst, run, ready, redir, target, v, instr, instr_pc, addr, halted, count
        tbl.push_back('{1, 0, 0, 0, 0,     0, 0,     0,     0,     0, 0});
        tbl.push_back('{0, 1, 1, 0, 0,     0, 0,     0,     0,     0, 0});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0,    0,     4,     0, 1});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0+1,  4,     8,     0, 2});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0+2,  8,     12,    0, 3});
        // back-pressure: two entries held, PC frozen at 8
        tbl.push_back('{1, 0, 0, 0, 0,     0, 0,     0,     0,     0, 0});
        tbl.push_back('{0, 1, 0, 0, 0,     0, 0,     0,     0,     0, 0});
        tbl.push_back('{0, 1, 0, 0, 0,     1, W0,    0,     4,     0, 1});
        tbl.push_back('{0, 1, 0, 0, 0,     1, W0,    0,     8,     0, 2});
        tbl.push_back('{0, 1, 0, 0, 0,     1, W0,    0,     8,     0, 2});
        tbl.push_back('{0, 1, 0, 0, 0,     1, W0,    0,     8,     0, 2});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0+1,  4,     12,    0, 3});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0+2,  8,     16,    0, 4});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0+3,  12,    20,    0, 5});
        // redirect while full, misaligned target
        tbl.push_back('{0, 1, 0, 1, 32'h22, 0, 0,    0,     32'h20, 0, 5});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0+8,  32'h20, 32'h24, 0, 6});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0+9,  32'h24, 32'h28, 0, 7});
        // Run low: drain, idle, restart
        tbl.push_back('{0, 0, 1, 0, 0,     0, 0,     0,     32'h28, 0, 7});
        tbl.push_back('{0, 0, 1, 0, 0,     0, 0,     0,     32'h28, 0, 7});
        tbl.push_back('{0, 1, 1, 0, 0,     0, 0,     0,     32'h28, 0, 7});
        tbl.push_back('{0, 1, 1, 0, 0,     1, W0+10, 32'h28, 32'h2C, 0, 8});

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) begin
                do_reset($sformatf("tbl[%0d] reset", i));
            end else begin
                apply(tbl[i].run, tbl[i].ready, tbl[i].redir, tbl[i].target);
                check_all($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].ins, tbl[i].ipc,
                          tbl[i].addr, tbl[i].h, tbl[i].cnt);
            end
        end

        // Halt word at PC 12: FIFO drains, no further captures, redirect resumes.
        mem[3] = HALT;
        do_reset("t4 reset");
        apply(1, 0, 0, 0); check_all("t4 start",    0, 0,    0, 0,  0, 0);
        apply(1, 0, 0, 0); check_all("t4 cap0",     1, W0,   0, 4,  0, 1);
        apply(1, 0, 0, 0); check_all("t4 full",     1, W0,   0, 8,  0, 2);
        apply(1, 1, 0, 0); check_all("t4 pop0",     1, W0+1, 4, 12, 0, 3);
        apply(1, 1, 0, 0); check_all("t4 halt",     1, W0+2, 8, 12, 1, 3);
        apply(1, 1, 0, 0); check_all("t4 drained",  0, 0,    0, 12, 1, 3);
        apply(1, 1, 0, 0); check_all("t4 stay",     0, 0,    0, 12, 1, 3);
        apply(1, 1, 1, 0); check_all("t4 redirect", 0, 0,    0, 0,  0, 3);
        apply(1, 1, 0, 0); check_all("t4 resume",   1, W0,   0, 4,  0, 4);

        // Redirect in the same cycle as the halt word and as a pop.
        do_reset("t6 reset");
        apply(1, 0, 0, 0); check_all("t6 start", 0, 0,    0, 0,  0, 0);
        apply(1, 0, 0, 0); check_all("t6 cap0",  1, W0,   0, 4,  0, 1);
        apply(1, 0, 0, 0); check_all("t6 full",  1, W0,   0, 8,  0, 2);
        apply(1, 1, 0, 0); check_all("t6 pop",   1, W0+1, 4, 12, 0, 3);
        apply(1, 1, 1, 32'h40); check_all("t6 collide", 0, 0, 0, 32'h40, 0, 3);
        apply(1, 0, 0, 0); check_all("t6 after", 1, W0+16, 32'h40, 32'h44, 0, 4);
        mem[3] = W0 + 32'd3;

        // PC wrap from 0xFFFF_FFFC, then reset asserted mid-stall.
        rst2 = 1'b1;
        #2;
        check("t5 reset addr", bus2.imem_address, 32'hFFFF_FFFC);
        rst2 = 1'b0;
        bus2.run = 1'b1;
        bus2.instr_ready = 1'b0;
        @(posedge clk); #1;
        check("t5 start valid", 32'(bus2.instr_valid), 32'd0);
        @(posedge clk); #1;
        check("t5 first instr", bus2.instr, 32'h1234_5678);
        check("t5 first pc", bus2.instr_pc, 32'hFFFF_FFFC);
        check("t5 wrap addr", bus2.imem_address, 32'h0000_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5 stall addr", bus2.imem_address, 32'h0000_0004);
        check("t5 stall count", bus2.fetch_count, 32'd2);
        #2;
        rst2 = 1'b1;
        #1;
        check("t5 async valid", 32'(bus2.instr_valid), 32'd0);
        check("t5 async instr", bus2.instr, 32'd0);
        check("t5 async instr_pc", bus2.instr_pc, 32'd0);
        check("t5 async addr", bus2.imem_address, 32'hFFFF_FFFC);
        check("t5 async count", bus2.fetch_count, 32'd0);
        check("t5 async halted", 32'(bus2.halted), 32'd0);
        @(posedge clk); #1;
        bus2.run = 1'b0;
        rst2 = 1'b0;

        // Randomized traffic against the reference model.
        for (int k = 0; k < 64; k++)
            mem[k] = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
        do_reset("rnd reset");
        mq.delete();
        m_pc = 32'd0;
        m_cnt = 32'd0;
        m_fetching = 1'b0;
        m_halted = 1'b0;
        for (int n = 0; n < 600; n++) begin
            r_run   = ($urandom_range(0, 9) != 0);
            r_ready = ($urandom_range(0, 2) != 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                   : 32'($urandom_range(0, 255));
            m_word = mem_read(m_pc);
            m_pop  = (mq.size() != 0) && r_ready && !r_redir;
            if (r_redir) begin
                mq.delete();
                m_pc = r_target & 32'hFFFF_FFFC;
                if (m_halted) begin
                    m_halted = 1'b0;
                    m_fetching = 1'b1;
                end
            end else begin
                if (m_pop) mq.delete(0);
                if (m_halted) begin
                    m_halted = 1'b1;
                end else if (!m_fetching) begin
                    m_fetching = r_run;
                end else if (!r_run) begin
                    m_fetching = 1'b0;
                end else if (mq.size() < DEPTH) begin
                    if (m_word == HALT) begin
                        m_fetching = 1'b0;
                        m_halted = 1'b1;
                    end else begin
                        mq.push_back('{w: m_word, p: m_pc});
                        m_pc = m_pc + 32'd4;
                        m_cnt = m_cnt + 32'd1;
                    end
                end
            end
            apply(r_run, r_ready, r_redir, r_target);
            if (mq.size() != 0)
                check_all($sformatf("rnd[%0d]", n), 1'b1, mq[0].w, mq[0].p, m_pc, m_halted, m_cnt);
            else
                check_all($sformatf("rnd[%0d]", n), 1'b0, 32'd0, 32'd0, m_pc, m_halted, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
